arinc429_tx_fifo: RTL and testbench
===================================

Name: arinc429_tx_fifo

Overview:
- Parametrised ARINC 429 transmitter with an input word FIFO.
- Serialises 32-bit words onto a bipolar return-to-zero line pair (TxA/TxB).
- Bit rate is selectable per word (high speed 100 kbit/s or low speed 12.5 kbit/s), with an optional auto-generated odd parity and a configurable inter-word gap.
- Sits between the host/word source and the line driver. It is the next-generation transmit path for arinc429, running from the 24 MHz system clock.

Parameters:
- CLKS_PER_BIT_HI, 240: Clk cycles per bit cell at high speed. Must be even.
- CLKS_PER_BIT_LO, 1920: Clk cycles per bit cell at low speed. Must be even.
- GAP_BITS, 4: null bit-times inserted after every word. Minimum 4.
- DEPTH, 8: FIFO depth in words. Must be a power of two, at least 2.
- PAR_MODE, 1:
  - 0 = bit 31 is sent as written.
  - 1 = bit 31 is replaced by odd parity over data_in[30:0].

Ports:
- Clk  in  1  system clock (24 MHz nominal).
- Rst_n  in  1  asynchronous, active-low reset.
- data_in  in  32  word to queue. Bit 0 (label LSB position) is transmitted first.
- wr_en  in  1  write strobe. Sampled on rising Clk.
- speed_hi  in  1  1 = high speed, 0 = low speed. Stored alongside each word at write.
- full  out  1  FIFO holds DEPTH words.
- fifo_count  out  $clog2(DEPTH+1)  words currently queued.
- ovf  out  1  one-cycle pulse when a write is dropped because the FIFO is full.
- busy  out  1  high in DATA or GAP state.
- tx_done  out  1  one-cycle pulse on the last cycle of a word's gap.
- TxA  out  1  line HI drive.
- TxB  out  1  line LO drive.

Behaviour:
- Clocking and reset:
  - One clock, Clk. Reset is asynchronous and active-low on Rst_n.
  - Reset state: all outputs 0, FIFO empty, state IDLE.
  - A reset mid-word forces TxA=TxB=0 immediately (asynchronously). The word in flight and all queued words are discarded.
- Line encoding, per bit cell:
  - First half (CPB/2 cycles): TxA=1,TxB=0 for a '1'; TxA=0,TxB=1 for a '0'.
  - Second half (CPB/2 cycles): NULL, TxA=TxB=0.
  - TxA and TxB must never both be 1. Both are registered outputs.
- FIFO writes:
  - A write is accepted only when full=0 in that cycle (registered).
  - A write while full is dropped and raises ovf the next cycle. This holds even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves the count unchanged.
- States: IDLE, DATA, GAP.
- IDLE:
  - If fifo_count>0: pop the head word and its speed bit, apply parity per PAR_MODE, load bit_idx=0 and cycle counter=0, then go to DATA.
  - Latency: a word written at cycle t into an empty FIFO while IDLE gives fifo_count=1 at t+1, pop at t+1, and first half-cell driven from t+2.
- DATA:
  - The counter runs 0..CPB-1 per bit, with CPB chosen by the latched speed.
  - After bit 31 completes its NULL half, go to GAP.
  - Word duration is exactly 32*CPB cycles.
- GAP:
  - NULL for GAP_BITS*CPB cycles, with tx_done pulsed on the last cycle.
  - On that last cycle: if fifo_count>0, pop and go directly to DATA. Back-to-back period is exactly (32+GAP_BITS)*CPB cycles. Otherwise go to IDLE.
- speed_hi changes never affect a word already popped.
- Parity (PAR_MODE=1): transmitted bit 31 = ~^data_in[30:0], i.e. the total number of ones is odd.

Decomposition:
- arinc429_pkg:
  - WORD_BITS=32.
  - State enum {IDLE, DATA, GAP}.
  - Line-state encodings HI/LO/NULL.
  - Parity function.
- One sub-module, arinc429_word_fifo:
  - Synchronous, DEPTH x 33 bits (word plus speed).
  - Provides count, full and empty.
- The top level holds the FSM, serialiser and line encoder.

Test Plan:
- Reset values: hold Rst_n=0 with wr_en toggling -> all outputs 0, fifo_count=0, nothing accepted.
- Single high-speed word, 32'hABDCABAB, PAR_MODE=1, write at t:
  - TxA high t+2..t+121 (bit0=1), then NULL 120 cycles.
  - bit2 is LO (TxB high).
  - Transmitted bit31=0 (19 ones in [30:0]).
  - tx_done pulses at t+2+8639.
- Same word with speed_hi=0 -> half cells are 960 cycles; tx_done pulses at t+2+69119.
- Three back-to-back high-speed words -> first-bit starts exactly 8640 cycles apart; 960 NULL cycles precede each next word; busy is never low between them.
- Overflow, DEPTH=8, 10 consecutive writes from IDLE:
  - The first word pops at t+1.
  - full=1 at t+9; the 10th write is dropped, ovf pulses at t+10, fifo_count=8.
- Reset mid-word: assert Rst_n=0 during bit 10 -> TxA=TxB=0 within the same cycle; after release, FIFO is empty and the line stays NULL.

Source files
------------

// File: rtl/arinc429_pkg.sv
// Shared constants, state/line encodings and the parity helper for the
// ARINC 429 transmit path.
package arinc429_pkg;

  localparam int WORD_BITS = 32;
  localparam int IDX_W     = $clog2(WORD_BITS);

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t DATA = 2'd1;
  localparam state_t GAP  = 2'd2;

  // Line pair packed as {TxA, TxB}; 2'b11 is never produced.
  typedef logic [1:0] line_t;

  localparam line_t LINE_NULL = 2'b00;
  localparam line_t LINE_HI   = 2'b10;
  localparam line_t LINE_LO   = 2'b01;

  // Bit 31 becomes odd parity over bits 30..0 when enabled.
  function automatic logic [WORD_BITS-1:0] apply_parity(
    input logic [WORD_BITS-1:0] word,
    input logic                 enable
  );
    logic [WORD_BITS-1:0] result;
    result = word;
    if (enable) begin
      result[WORD_BITS-1] = ~^word[WORD_BITS-2:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/arinc429_tx_fifo_if.sv
// Host-side word interface and line/status outputs of the ARINC 429
// transmitter; master is the host, slave is the transmitter.
interface arinc429_tx_fifo_if
  import arinc429_pkg::*;
#(
  parameter int DEPTH = 8
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WORD_BITS-1:0] data_in;
  logic                 wr_en;
  logic                 speed_hi;
  logic                 full;
  logic [CNT_W-1:0]     fifo_count;
  logic                 ovf;
  logic                 busy;
  logic                 tx_done;
  logic                 TxA;
  logic                 TxB;

  modport master (
    output data_in, wr_en, speed_hi,
    input  full, fifo_count, ovf, busy, tx_done, TxA, TxB
  );

  modport slave (
    input  data_in, wr_en, speed_hi,
    output full, fifo_count, ovf, busy, tx_done, TxA, TxB
  );

endinterface

// File: rtl/arinc429_word_fifo.sv
// Show-ahead synchronous FIFO holding each queued word together with its
// speed bit; writes while full and pops while empty are ignored.
module arinc429_word_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 33,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/arinc429_tx_fifo.sv
// ARINC 429 transmitter: word FIFO, IDLE/DATA/GAP sequencer, serialiser and
// bipolar return-to-zero line encoder with registered TxA/TxB.
module arinc429_tx_fifo
  import arinc429_pkg::*;
#(
  parameter int CLKS_PER_BIT_HI = 240,
  parameter int CLKS_PER_BIT_LO = 1920,
  parameter int GAP_BITS        = 4,
  parameter int DEPTH           = 8,
  parameter int PAR_MODE        = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  arinc429_tx_fifo_if.slave   bus
);

  localparam int CPB_MAX = (CLKS_PER_BIT_HI > CLKS_PER_BIT_LO) ?
                           CLKS_PER_BIT_HI : CLKS_PER_BIT_LO;
  localparam int CW      = $clog2(GAP_BITS * CPB_MAX + 1);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] HI_LAST     = CW'(CLKS_PER_BIT_HI - 1);
  localparam logic [CW-1:0] LO_LAST     = CW'(CLKS_PER_BIT_LO - 1);
  localparam logic [CW-1:0] HI_HALF     = CW'(CLKS_PER_BIT_HI / 2);
  localparam logic [CW-1:0] LO_HALF     = CW'(CLKS_PER_BIT_LO / 2);
  localparam logic [CW-1:0] GAP_HI_LAST = CW'(GAP_BITS * CLKS_PER_BIT_HI - 1);
  localparam logic [CW-1:0] GAP_LO_LAST = CW'(GAP_BITS * CLKS_PER_BIT_LO - 1);

  state_t               state;
  state_t               state_n;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_n;
  logic [WORD_BITS-1:0] word;
  logic [WORD_BITS-1:0] word_n;
  logic                 spd;
  logic                 spd_n;
  logic                 pop;
  logic [WORD_BITS:0]   head;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic                 ovf;
  logic [CW-1:0]        bit_last;
  logic [CW-1:0]        gap_last;
  line_t                line_n;
  line_t                line_q;

  arinc429_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_BITS + 1)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .wr_en   (bus.wr_en),
    .wr_data ({bus.speed_hi, bus.data_in}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign bit_last = spd ? HI_LAST : LO_LAST;
  assign gap_last = spd ? GAP_HI_LAST : GAP_LO_LAST;

  // Sequencer: a pop reloads the serialiser from the FIFO head, both from
  // IDLE and on the final gap cycle so back-to-back words abut exactly.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    word_n  = word;
    spd_n   = spd;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
        end
      end
      DATA: begin
        if (cnt == bit_last) begin
          cnt_n = '0;
          if (idx == IDX_W'(WORD_BITS - 1)) begin
            state_n = GAP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == gap_last) begin
          cnt_n = '0;
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (pop) begin
      state_n = DATA;
      cnt_n   = '0;
      idx_n   = '0;
      word_n  = apply_parity(head[WORD_BITS-1:0], PAR_MODE != 0);
      spd_n   = head[WORD_BITS];
    end
  end

  // The line is encoded from the next state so the registered outputs line
  // up with the cell the sequencer is entering.
  always_comb begin
    line_n = LINE_NULL;
    if (state_n == DATA && cnt_n < (spd_n ? HI_HALF : LO_HALF)) begin
      line_n = word_n[idx_n] ? LINE_HI : LINE_LO;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      word   <= '0;
      spd    <= 1'b0;
      line_q <= LINE_NULL;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      word   <= word_n;
      spd    <= spd_n;
      line_q <= line_n;
      ovf    <= bus.wr_en && full;
    end
  end

  assign bus.TxA        = line_q[1];
  assign bus.TxB        = line_q[0];
  assign bus.busy       = (state == DATA) || (state == GAP);
  assign bus.tx_done    = (state == GAP) && (cnt == gap_last);
  assign bus.full       = full;
  assign bus.fifo_count = count;
  assign bus.ovf        = ovf;

endmodule

// File: tb/tb_arinc429_tx_fifo.sv
// Bench for arinc429_tx_fifo: timestamp-based reference model checked every
// cycle, plus directed timing checks taken from the line-timing rules.
`timescale 1ns/1ps
module tb_arinc429_tx_fifo;

  localparam int HI    = 240;
  localparam int LO    = 1920;
  localparam int GAPB  = 4;
  localparam int DEPTH = 8;
  localparam int NBITS = 32;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;

  arinc429_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  arinc429_tx_fifo #(
    .CLKS_PER_BIT_HI (HI),
    .CLKS_PER_BIT_LO (LO),
    .GAP_BITS        (GAPB),
    .DEPTH           (DEPTH),
    .PAR_MODE        (1)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #20 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [32:0] q [$];
  bit          act     = 1'b0;
  int          start   = 0;
  int          cpb     = HI;
  logic [31:0] cur     = '0;
  bit          exp_ovf = 1'b0;
  bit          gap_dirty;
  bit          busy_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] with_parity(input logic [31:0] d);
    logic [31:0] r;
    logic [30:0] low;
    r   = d;
    low = d[30:0];
    r[31] = ($countones(low) % 2 == 0);
    return r;
  endfunction

  function automatic logic [31:0] observed_vec();
    return 32'({bus.TxA, bus.TxB, bus.busy, bus.tx_done, bus.full, bus.ovf, bus.fifo_count});
  endfunction

  // Reference: each word owns the window [start, start+(32+GAPB)*cpb).
  task automatic model_update();
    bit          full_prev;
    logic [32:0] e;
    cyc++;
    if (!Rst_n) begin
      q.delete();
      act     = 1'b0;
      exp_ovf = 1'b0;
      return;
    end
    full_prev = (q.size() == DEPTH);
    if (act && (cyc - 1 == start + (NBITS + GAPB) * cpb - 1)) begin
      act = 1'b0;
    end
    if (!act && q.size() > 0) begin
      e     = q.pop_front();
      cur   = with_parity(e[31:0]);
      cpb   = e[32] ? HI : LO;
      start = cyc;
      act   = 1'b1;
    end
    exp_ovf = bus.wr_en && full_prev;
    if (bus.wr_en && !full_prev) begin
      q.push_back({bus.speed_hi, bus.data_in});
    end
  endtask

  function automatic logic [31:0] expected_vec();
    logic a, b, bs, dn;
    int   off;
    a = 1'b0; b = 1'b0; bs = 1'b0; dn = 1'b0;
    if (act) begin
      off = cyc - start;
      bs  = 1'b1;
      if (off < NBITS * cpb && (off % cpb) < cpb / 2) begin
        a = cur[off / cpb];
        b = !cur[off / cpb];
      end
      dn = (off == (NBITS + GAPB) * cpb - 1);
    end
    return 32'({a, b, bs, dn, (q.size() == DEPTH), exp_ovf, 4'(q.size())});
  endfunction

  task automatic check_output();
    check("cycle_model", observed_vec(), expected_vec());
  endtask

  task automatic apply_stimulus(input bit wr, input logic [31:0] d, input bit hs);
    bus.wr_en    = wr;
    bus.data_in  = d;
    bus.speed_hi = hs;
  endtask

  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
    check_output();
  endtask

  task automatic dir_b2b(input int t);
    int rel;
    rel = cyc - t;
    if (rel == 2)             check("b2b_bit0_start", 32'(bus.TxA), 1);
    if (rel == 121)           check("b2b_bit0_half_end", 32'(bus.TxA), 1);
    if (rel == 122)           check("b2b_bit0_null", 32'({bus.TxA, bus.TxB}), 0);
    if (rel == 2 + 2 * HI)    check("b2b_bit2_lo", 32'({bus.TxA, bus.TxB}), 1);
    if (rel == 2 + 31 * HI)   check("b2b_bit31_parity", 32'({bus.TxA, bus.TxB}), 1);
    if (rel == 2 + 8638)      check("b2b_done_early", 32'(bus.tx_done), 0);
    if (rel == 2 + 8639)      check("b2b_done", 32'(bus.tx_done), 1);
    if (rel == 2 + 8640)      check("b2b_word2_start", 32'(bus.TxA | bus.TxB), 1);
    if (rel == 2 + 8640 + 8639) check("b2b_word2_done", 32'(bus.tx_done), 1);
    if (rel == 2 + 17280)     check("b2b_word3_start", 32'(bus.TxA | bus.TxB), 1);
    if ((rel >= 2 + NBITS * HI && rel < 2 + 8640) ||
        (rel >= 2 + 8640 + NBITS * HI && rel < 2 + 17280)) begin
      if (bus.TxA || bus.TxB) gap_dirty = 1'b1;
    end
    if (rel >= 2 && rel <= 2 + 17280 && !bus.busy) busy_gap = 1'b1;
  endtask

  task automatic dir_ls(input int t);
    int rel;
    rel = cyc - t;
    if (rel == 2)             check("ls_bit0_start", 32'(bus.TxA), 1);
    if (rel == 961)           check("ls_bit0_half_end", 32'(bus.TxA), 1);
    if (rel == 962)           check("ls_bit0_null", 32'({bus.TxA, bus.TxB}), 0);
    if (rel == 2 + 69118)     check("ls_done_early", 32'(bus.tx_done), 0);
    if (rel == 2 + 69119)     check("ls_done", 32'(bus.tx_done), 1);
    if (rel == 2 + 69120)     check("ls_idle_after", 32'(bus.busy), 0);
  endtask

  task automatic dir_ovf(input int t);
    int rel;
    rel = cyc - t;
    if (rel == 1)  check("ovf_count_t1", 32'(bus.fifo_count), 1);
    if (rel == 2)  check("ovf_popped_busy", 32'(bus.busy), 1);
    if (rel == 8)  check("ovf_not_full_t8", 32'(bus.full), 0);
    if (rel == 9)  check("ovf_full_t9", 32'(bus.full), 1);
    if (rel == 9)  check("ovf_no_pulse_t9", 32'(bus.ovf), 0);
    if (rel == 10) check("ovf_pulse_t10", 32'(bus.ovf), 1);
    if (rel == 10) check("ovf_count_t10", 32'(bus.fifo_count), 8);
    if (rel == 11) check("ovf_pulse_end", 32'(bus.ovf), 0);
  endtask

  initial begin
    int t;
    apply_stimulus(1'b0, 32'h0, 1'b1);
    Rst_n = 1'b0;

    $display("[TB] reset with write strobes toggling");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(i[0], $urandom, 1'b1);
      step();
    end
    check("reset_outputs", observed_vec(), 0);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("[TB] three back-to-back high-speed words");
    gap_dirty = 1'b0;
    busy_gap  = 1'b0;
    t = cyc;
    apply_stimulus(1'b1, 32'hABDCABAB, 1'b1);
    step(); dir_b2b(t);
    apply_stimulus(1'b1, $urandom, 1'b1);
    step(); dir_b2b(t);
    apply_stimulus(1'b1, $urandom, 1'b1);
    bus.speed_hi = 1'b1;
    step(); dir_b2b(t);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    while (cyc - t < 2 + 17280 + 5) begin
      if ((cyc % 97) == 0) bus.speed_hi = 1'($urandom);
      step(); dir_b2b(t);
    end
    check("b2b_gap_null", 32'(gap_dirty), 0);
    check("b2b_busy_continuous", 32'(busy_gap), 0);
    Rst_n = 1'b0;
    step(); step();
    Rst_n = 1'b1;
    step();

    $display("[TB] single low-speed word");
    t = cyc;
    apply_stimulus(1'b1, 32'hABDCABAB, 1'b0);
    step(); dir_ls(t);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    while (cyc - t < 2 + 69120 + 2) begin
      step(); dir_ls(t);
    end

    $display("[TB] overflow burst then reset during bit 10");
    t = cyc;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, $urandom, 1'b1);
      step(); dir_ovf(t);
    end
    apply_stimulus(1'b0, 32'h0, 1'b1);
    while (cyc - t < 2 + 10 * HI + 5) begin
      step(); dir_ovf(t);
    end
    check("bit10_driven", 32'(bus.TxA | bus.TxB), 1);
    Rst_n = 1'b0;
    #1;
    check("async_reset", observed_vec(), 0);
    q.delete();
    act     = 1'b0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 3; i++) step();
    Rst_n = 1'b1;
    for (int i = 0; i < 600; i++) step();
    check("post_reset_idle", observed_vec(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
